// File: rtl/surya_alarm_scheduler.sv
// surya_alarm_scheduler: multi-slot absolute-time alarm scheduler.
// Ticks are evaluated against per-slot due times; due slots are issued one at
// a time through a valid/ready event port in round-robin order.
// Optional feature macro: SSCHED_PERIODIC_EN (periodic reload on issue);
// without it every slot is one-shot and req_period is ignored.
module surya_alarm_scheduler #(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned TW        = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tick_in,
  input  logic [TW-1:0]                time_now,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [$clog2(NUM_SLOTS)-1:0] req_slot,
  input  logic                         req_cancel,
  input  logic [TW-1:0]                req_target,
  input  logic [15:0]                  req_period,
  output logic                         evt_valid,
  input  logic                         evt_ready,
  output logic [$clog2(NUM_SLOTS)-1:0] evt_slot,
  output logic [TW-1:0]                evt_time,
  output logic [NUM_SLOTS-1:0]         slot_armed,
  output logic [NUM_SLOTS-1:0]         overrun,
  output logic [7:0]                   missed_ticks
);

  localparam int unsigned SW = $clog2(NUM_SLOTS);
  localparam int unsigned PW = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_ARB  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [TW-1:0]          r_target [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]   r_armed;
  logic [NUM_SLOTS-1:0]   r_pending;
  logic [NUM_SLOTS-1:0]   r_overrun;
  logic [TW-1:0]          r_tcap;
  logic                   r_lat_v;
  logic [TW-1:0]          r_lat_t;
  logic [7:0]             r_missed;
  logic [SW-1:0]          r_rr;
  logic                   r_evt_valid;
  logic [SW-1:0]          r_evt_slot;
  logic [TW-1:0]          r_evt_time;

  logic [NUM_SLOTS-1:0]   w_due;
  logic [NUM_SLOTS-1:0]   w_busy;
  logic [NUM_SLOTS-1:0]   w_new_pend;
  logic [NUM_SLOTS-1:0]   w_new_ovr;
  logic [NUM_SLOTS-1:0]   w_pend_eval;
  logic [NUM_SLOTS-1:0]   w_pick_mask;
  logic                   w_found;
  logic [SW-1:0]          w_pick;
  logic                   w_issue_ok;
  logic                   w_start;
  logic                   w_do_eval;
  logic                   w_do_issue;
  logic                   w_tick_to_latch;
  logic                   w_req_fire;

`ifdef SSCHED_PERIODIC_EN
  logic [PW-1:0]          r_period [NUM_SLOTS];
`else
  logic                   w_unused_period;
  assign w_unused_period = ^req_period;
`endif

  // Wrap-safe "now has reached target": difference taken modulo 2^TW, MSB clear.
  function automatic logic is_due(input logic [TW-1:0] now, input logic [TW-1:0] tgt);
    logic [TW-1:0] d;
    d = now - tgt;
    return ~d[TW-1];
  endfunction

  assign req_ready    = (r_state == S_IDLE) && !tick_in && !r_lat_v;
  assign w_req_fire   = req_valid && req_ready && (32'(req_slot) < NUM_SLOTS);
  assign evt_valid    = r_evt_valid;
  assign evt_slot     = r_evt_slot;
  assign evt_time     = r_evt_time;
  assign slot_armed   = r_armed;
  assign overrun      = r_overrun;
  assign missed_ticks = r_missed;

  // A tick goes straight to evaluation only when idle with an empty latch.
  assign w_tick_to_latch = tick_in && !((r_state == S_IDLE) && !r_lat_v);

  // Due detection; a slot whose event still sits in the output register counts as pending.
  always_comb begin
    w_due  = '0;
    w_busy = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_due[i]  = r_armed[i] && is_due(r_tcap, r_target[i]);
      w_busy[i] = r_pending[i] || (r_evt_valid && (r_evt_slot == SW'(i)));
    end
  end

  assign w_new_pend  = w_due & ~w_busy;
  assign w_new_ovr   = w_due & w_busy;
  assign w_pend_eval = r_pending | w_new_pend;

  // Round-robin search for the first pending slot after the last issued one.
  always_comb begin : p_pick
    int unsigned v_idx;
    v_idx   = 0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 1; k <= NUM_SLOTS; k++) begin
      v_idx = 32'(r_rr) + 32'(k);
      if (v_idx >= NUM_SLOTS) v_idx = v_idx - NUM_SLOTS;
      if (!w_found && r_pending[SW'(v_idx)]) begin
        w_found = 1'b1;
        w_pick  = SW'(v_idx);
      end
    end
  end

  assign w_pick_mask = NUM_SLOTS'(1) << w_pick;
  assign w_issue_ok  = w_found && (!r_evt_valid || evt_ready);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state and control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_do_eval   = 1'b0;
    w_do_issue  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (tick_in || r_lat_v) begin
          w_start     = 1'b1;
          w_state_nxt = S_EVAL;
        end
      end
      S_EVAL: begin
        w_do_eval   = 1'b1;
        w_state_nxt = (|w_pend_eval) ? S_ARB : S_IDLE;
      end
      S_ARB: begin
        w_do_issue = w_issue_ok;
        if ((r_pending & ~(w_issue_ok ? w_pick_mask : '0)) == '0) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: tick latch, slot table, pending/overrun, event register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_target[i] <= '0;
`ifdef SSCHED_PERIODIC_EN
        r_period[i] <= '0;
`endif
      end
      r_armed     <= '0;
      r_pending   <= '0;
      r_overrun   <= '0;
      r_tcap      <= '0;
      r_lat_v     <= 1'b0;
      r_lat_t     <= '0;
      r_missed    <= '0;
      r_rr        <= SW'(NUM_SLOTS - 1);
      r_evt_valid <= 1'b0;
      r_evt_slot  <= '0;
      r_evt_time  <= '0;
    end else begin
      if (w_start) r_tcap <= r_lat_v ? r_lat_t : time_now;

      if (w_tick_to_latch) begin
        if (r_lat_v && !w_start && (r_missed != 8'hFF)) r_missed <= r_missed + 8'd1;
        r_lat_v <= 1'b1;
        r_lat_t <= time_now;
      end else if (w_start) begin
        r_lat_v <= 1'b0;
      end

      if (w_do_eval) begin
        r_pending <= w_pend_eval;
        r_overrun <= r_overrun | w_new_ovr;
      end

      if (w_do_issue) begin
        r_evt_valid         <= 1'b1;
        r_evt_slot          <= w_pick;
        r_evt_time          <= r_target[w_pick];
        r_pending[w_pick]   <= 1'b0;
        r_rr                <= w_pick;
`ifdef SSCHED_PERIODIC_EN
        if (r_period[w_pick] != '0) r_target[w_pick] <= r_target[w_pick] + TW'(r_period[w_pick]);
        else                        r_armed[w_pick]  <= 1'b0;
`else
        r_armed[w_pick]     <= 1'b0;
`endif
      end else if (evt_ready) begin
        r_evt_valid <= 1'b0;
      end

      if (w_req_fire) begin
        r_pending[req_slot] <= 1'b0;
        if (req_cancel) begin
          r_armed[req_slot] <= 1'b0;
        end else begin
          r_armed[req_slot]   <= 1'b1;
          r_overrun[req_slot] <= 1'b0;
          r_target[req_slot]  <= req_target;
`ifdef SSCHED_PERIODIC_EN
          r_period[req_slot]  <= req_period;
`endif
        end
      end
    end
  end

endmodule

// File: doc/surya_alarm_scheduler.md
SURYA_ALARM_SCHEDULER -- requirements
Module: surya_alarm_scheduler

Interface
REQ-001 Parameter NUM_SLOTS, default 4, number of alarm slots; legal range 2..8.
REQ-002 Parameter TW, default 32, width of timestamps.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 tick_in  input  1  one-cycle pulse when the timer unit advances.
REQ-006 time_now  input  TW  current count of the selected time unit; valid when tick_in is high.
REQ-007 req_valid / req_ready  input / output  1 / 1  programming handshake; transfer when both are high.
REQ-008 req_slot, req_cancel, req_target, req_period  input  clog2(NUM_SLOTS), 1, TW, 16  slot index, disarm flag, absolute due time, reload period (0 = one-shot).
REQ-009 evt_valid / evt_ready  output / input  1 / 1  alarm event handshake.
REQ-010 evt_slot, evt_time  output  clog2(NUM_SLOTS), TW  firing slot and its due time.
REQ-011 slot_armed, overrun  output  NUM_SLOTS each  armed mask; sticky per-slot overrun flags.
REQ-012 missed_ticks  output  8  saturating count of dropped ticks.

Function
REQ-013 The FSM SHALL have three states: IDLE, EVAL and ARB.
REQ-014 IDLE -> EVAL SHALL occur on tick_in or a latched tick, and SHALL capture time_now, or the value latched with the tick, as t_cap.
REQ-015 In EVAL, each armed, non-pending slot with (t_cap - target) mod 2^TW having MSB 0 SHALL set pending; a slot already pending and due again SHALL set its overrun bit instead.
REQ-016 EVAL SHALL go to ARB if any pending bit is set, otherwise to IDLE; EVAL SHALL last exactly one cycle.
REQ-017 In ARB, when evt_valid is 0 or evt_ready is 1, the block SHALL load the next pending slot in round-robin order, starting after the last issued slot, into evt_slot/evt_time, assert evt_valid next cycle, and clear that pending bit.
REQ-018 When an event is issued, a slot with period != 0 SHALL set target += period modulo 2^TW and stay armed; a slot with period == 0 SHALL be disarmed.
REQ-019 ARB SHALL return to IDLE once no bit is pending; evt_valid SHALL stay high with stable payload until accepted, independent of state.
REQ-020 req_ready SHALL be 1 only in IDLE with tick_in low and no latched tick; a write SHALL load target and period, arm the slot, and clear its pending and overrun bits.
REQ-021 A cancel write SHALL disarm the slot and clear pending; an event already in the evt register SHALL still be delivered.
REQ-022 A tick arriving outside IDLE SHALL set a one-deep tick latch holding time_now; a further tick while the latch is full SHALL increment missed_ticks (saturating at 255) and overwrite the latched time.
REQ-023 Event latency SHALL be 3 cycles from tick_in to evt_valid when the output register is empty.

Reset
REQ-024 Reset SHALL force IDLE, evt_valid=0, evt_slot=0, evt_time=0, slot_armed=0, overrun=0, pending=0, missed_ticks=0, the tick latch empty, and the round-robin pointer to slot NUM_SLOTS-1.
REQ-025 Reset asserted mid-ARB SHALL discard the pending and un-accepted events with no output glitch after release.

Configuration
REQ-026 With macro SSCHED_PERIODIC_EN defined, REQ-018 reload SHALL apply; without it, req_period SHALL be ignored, all slots SHALL be one-shot, and the port SHALL remain present.

Verification
REQ-027 Program slot 1 target=10 period=0; tick time_now=10 -> evt_slot=1, evt_time=10 three cycles later; slot_armed[1]=0.
REQ-028 Slots 0,2,3 are all due on the same tick with evt_ready=1 -> events issue in the order 0,2,3; the next simultaneous burst starts at 0 again, following round-robin after 3.
REQ-029 With SSCHED_PERIODIC_EN, slot 0 target=0xFFFFFFFE period=4 -> fires at 0xFFFFFFFE, then wraps and fires at time 2.
REQ-030 evt_ready=0 while slot 2 period=1 is due on consecutive ticks -> overrun[2]=1, a single event is held, missed_ticks increments once the latch overflows.
REQ-031 Cancel slot 1 before its due tick -> no event; rst_n pulse during ARB -> evt_valid=0 and all outputs at reset values.
